// File: rtl/spi_slave_word_if.sv
// Word-side bundle of the SPI slave: tx holding-register handshake, rx word strobe and frame status.
interface spi_slave_word_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             frame_active;
  logic             frame_done;
  logic             frame_abort;
  logic [15:0]      word_count;

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, tx_underrun,
           frame_active, frame_done, frame_abort, word_count
  );

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, tx_underrun,
           frame_active, frame_done, frame_abort, word_count
  );
endinterface

// File: rtl/spi_slave_word.sv
// Oversampling SPI slave: multi-word frames, any CPOL/CPHA, selectable bit order, tx holding register.
// Pins pass through in-fabric synchronisers; SCK must be at least 8 clk periods long.
module spi_slave_word #(
  parameter int   WIDTH     = 8,
  parameter int   CPOL      = 0,
  parameter int   CPHA      = 0,
  parameter int   MSB_FIRST = 1,
  parameter logic TX_FILL   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              ssel,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  spi_slave_word_if.slave   bus
);

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic          SCK_IDLE = (CPOL != 0);

  logic [2:0]       sck_s, ssel_s;
  logic [1:0]       mosi_s, prime;
  logic             armed, active, hold_full;
  logic [WIDTH-1:0] hold, tx_sh, rx_sh, rx_q, rx_next;
  logic [BW-1:0]    bitcnt;
  logic [15:0]      wcnt;
  logic             rx_vld_q, und_q, done_q, abort_q;

  logic sck_rise, sck_fall, lead_edge, trail_edge;
  logic ssel_fall, ssel_rise, frame_start, frame_end, edge_ok;
  logic sample, shift, load, accept;

  always_comb begin
    sck_rise    = sck_s[1] & ~sck_s[2];
    sck_fall    = ~sck_s[1] & sck_s[2];
    lead_edge   = (CPOL != 0) ? sck_fall : sck_rise;
    trail_edge  = (CPOL != 0) ? sck_rise : sck_fall;
    ssel_fall   = ssel_s[2] & ~ssel_s[1];
    ssel_rise   = ~ssel_s[2] & ssel_s[1];
    frame_start = ssel_fall & armed & ~active;
    frame_end   = ssel_rise & active;
    // A deassert in the same cycle as an SCK edge takes priority over the edge.
    edge_ok     = active & ~ssel_rise;
    sample      = edge_ok & ((CPHA != 0) ? trail_edge : lead_edge);
    shift       = edge_ok & ((CPHA != 0) ? lead_edge : trail_edge);
    load        = (shift & (bitcnt == '0)) | (frame_start & (CPHA == 0));
    accept      = bus.tx_valid & ~hold_full;
    rx_next     = (MSB_FIRST != 0) ? {rx_sh[WIDTH-2:0], mosi_s[1]}
                                   : {mosi_s[1], rx_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s     <= {3{SCK_IDLE}};
      ssel_s    <= 3'b111;
      mosi_s    <= '0;
      prime     <= '0;
      armed     <= 1'b0;
      active    <= 1'b0;
      miso_oe   <= 1'b0;
      hold_full <= 1'b0;
      hold      <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx_q      <= '0;
      bitcnt    <= '0;
      wcnt      <= '0;
      rx_vld_q  <= 1'b0;
      und_q     <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      sck_s    <= {sck_s[1:0], sck};
      ssel_s   <= {ssel_s[1:0], ssel};
      mosi_s   <= {mosi_s[0], mosi};
      rx_vld_q <= 1'b0;
      und_q    <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;

      // The ssel chain starts out as reset filler; only arm once real samples reach stage 1.
      prime <= {prime[0], 1'b1};
      if (prime[1] && ssel_s[1]) armed <= 1'b1;

      if (frame_start) begin
        bitcnt  <= '0;
        wcnt    <= '0;
        active  <= 1'b1;
        miso_oe <= 1'b1;
      end

      if (frame_end) begin
        active  <= 1'b0;
        miso_oe <= 1'b0;
        done_q  <= 1'b1;
        abort_q <= (bitcnt != '0);
        bitcnt  <= '0;
      end

      if (sample) begin
        rx_sh <= rx_next;
        if (bitcnt == LAST_BIT) begin
          bitcnt   <= '0;
          rx_q     <= rx_next;
          rx_vld_q <= 1'b1;
          if (wcnt != 16'hFFFF) wcnt <= wcnt + 16'd1;
        end else begin
          bitcnt <= bitcnt + BW'(1);
        end
      end

      if (shift && bitcnt != '0)
        tx_sh <= (MSB_FIRST != 0) ? {tx_sh[WIDTH-2:0], 1'b0} : {1'b0, tx_sh[WIDTH-1:1]};

      if (load) begin
        if (hold_full) begin
          tx_sh <= hold;
        end else begin
          tx_sh <= {WIDTH{TX_FILL}};
          und_q <= 1'b1;
        end
      end

      // Accept only happens while empty, so it never collides with a load that drains hold.
      if (accept) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end else if (load && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign miso             = (MSB_FIRST != 0) ? tx_sh[WIDTH-1] : tx_sh[0];
  assign bus.tx_ready     = ~hold_full;
  assign bus.rx_data      = rx_q;
  assign bus.rx_valid     = rx_vld_q;
  assign bus.tx_underrun  = und_q;
  assign bus.frame_active = active;
  assign bus.frame_done   = done_q;
  assign bus.frame_abort  = abort_q;
  assign bus.word_count   = wcnt;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: three configurations driven by a behavioural SPI master,
// with an rx scoreboard queue drained by a clock-edge monitor.
`timescale 1ns/1ps
module tb_spi_slave_word;

  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sck_v  = 3'b100;
  logic [2:0] ssel_v = 3'b111;
  logic       mosi   = 1'b0;
  logic [31:0] txd[3];
  logic [2:0] txv = '0;
  wire        miso_a, miso_b, miso_c, oe_a, oe_b, oe_c;

  always #5 clk = ~clk;

  spi_slave_word_if #(.WIDTH(8))  ifa ();
  spi_slave_word_if #(.WIDTH(8))  ifb ();
  spi_slave_word_if #(.WIDTH(16)) ifc ();

  assign ifa.tx_data  = txd[0][7:0];
  assign ifa.tx_valid = txv[0];
  assign ifb.tx_data  = txd[1][7:0];
  assign ifb.tx_valid = txv[1];
  assign ifc.tx_data  = txd[2][15:0];
  assign ifc.tx_valid = txv[2];

  spi_slave_word #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .TX_FILL(1'b0)) dut_a (
    .clk(clk), .reset(rst), .sck(sck_v[0]), .ssel(ssel_v[0]), .mosi(mosi),
    .miso(miso_a), .miso_oe(oe_a), .bus(ifa));
  spi_slave_word #(.WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .TX_FILL(1'b1)) dut_b (
    .clk(clk), .reset(rst), .sck(sck_v[1]), .ssel(ssel_v[1]), .mosi(mosi),
    .miso(miso_b), .miso_oe(oe_b), .bus(ifb));
  spi_slave_word #(.WIDTH(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .TX_FILL(1'b0)) dut_c (
    .clk(clk), .reset(rst), .sck(sck_v[2]), .ssel(ssel_v[2]), .mosi(mosi),
    .miso(miso_c), .miso_oe(oe_c), .bus(ifc));

  typedef struct {
    int          d;
    logic [31:0] w;
  } rx_exp_t;

  rx_exp_t     exp_q[$];
  int          checks = 0;
  int          fails  = 0;
  int          und_cnt[3];
  int          done_cnt[3];
  int          abort_cnt[3];
  logic [31:0] mw_g[4];
  logic [31:0] em_g[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int wid(input int d);   return (d == 2) ? 16 : 8; endfunction
  function automatic logic cpol(input int d); return (d == 2);          endfunction
  function automatic logic cpha(input int d); return (d != 0);          endfunction
  function automatic logic msbf(input int d); return (d != 2);          endfunction

  function automatic logic miso_of(input int d);
    case (d)
      0:       return miso_a;
      1:       return miso_b;
      default: return miso_c;
    endcase
  endfunction

  function automatic logic oe_of(input int d);
    case (d)
      0:       return oe_a;
      1:       return oe_b;
      default: return oe_c;
    endcase
  endfunction

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return ifa.tx_ready;
      1:       return ifb.tx_ready;
      default: return ifc.tx_ready;
    endcase
  endfunction

  function automatic logic [15:0] wc_of(input int d);
    case (d)
      0:       return ifa.word_count;
      1:       return ifb.word_count;
      default: return ifc.word_count;
    endcase
  endfunction

  // Scoreboard monitor: each rx_valid pops one expected word; strobes are tallied.
  task automatic mon(input int d, input logic rv, input logic [31:0] rd,
                     input logic un, input logic fd, input logic fa);
    rx_exp_t e;
    if (rv) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rx_unexpected: inst %0d got 0x%0h with nothing expected", d, rd);
      end else begin
        e = exp_q.pop_front();
        check("rx_inst", d, e.d);
        check("rx_data", rd, e.w);
      end
    end
    if (un) und_cnt[d]++;
    if (fd) done_cnt[d]++;
    if (fa) begin
      abort_cnt[d]++;
      check("abort_with_done", {31'd0, fd}, 32'd1);
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.rx_valid, {24'd0, ifa.rx_data}, ifa.tx_underrun, ifa.frame_done, ifa.frame_abort);
    mon(1, ifb.rx_valid, {24'd0, ifb.rx_data}, ifb.tx_underrun, ifb.frame_done, ifb.frame_abort);
    mon(2, ifc.rx_valid, {16'd0, ifc.rx_data}, ifc.tx_underrun, ifc.frame_done, ifc.frame_abort);
  end

  task automatic tx_push(input int d, input logic [31:0] v);
    int n = 0;
    @(negedge clk);
    while (!rdy_of(d) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      check("tx_ready_timeout", 32'd0, 32'd1);
    end else begin
      txd[d] = v;
      txv[d] = 1'b1;
      @(posedge clk);
      #1 txv[d] = 1'b0;
    end
  endtask

  // Master: mw_g holds MOSI words, em_g the expected MISO words; the last word may be partial.
  task automatic run_frame(input int d, input int nw, input int last_bits, input bit chk_miso,
                           input int wc_exp, input int und_exp, input int abort_exp);
    int u0 = und_cnt[d];
    int dn0 = done_cnt[d];
    int ab0 = abort_cnt[d];
    int bits, idx;
    logic [31:0] got;
    rx_exp_t e;
    ssel_v[d] = 1'b0;
    #(HALF);
    check("oe_in_frame", {31'd0, oe_of(d)}, 32'd1);
    for (int w = 0; w < nw; w++) begin
      bits = (w == nw - 1) ? last_bits : wid(d);
      if (bits == wid(d)) begin
        e.d = d;
        e.w = mw_g[w];
        exp_q.push_back(e);
      end
      got = '0;
      for (int i = 0; i < bits; i++) begin
        idx = msbf(d) ? wid(d) - 1 - i : i;
        if (!cpha(d)) begin
          mosi = mw_g[w][idx];
          #(HALF);
          got[idx] = miso_of(d);
          sck_v[d] = ~cpol(d);
          #(HALF);
          sck_v[d] = cpol(d);
        end else begin
          sck_v[d] = ~cpol(d);
          mosi = mw_g[w][idx];
          #(HALF);
          got[idx] = miso_of(d);
          sck_v[d] = cpol(d);
          #(HALF);
        end
      end
      if (chk_miso && bits == wid(d)) check("miso_word", got, em_g[w]);
    end
    #(HALF);
    ssel_v[d] = 1'b1;
    #(2 * HALF);
    check("oe_after_frame", {31'd0, oe_of(d)}, 32'd0);
    check("word_count", {16'd0, wc_of(d)}, wc_exp);
    check("underruns", und_cnt[d] - u0, und_exp);
    check("frame_done", done_cnt[d] - dn0, 1);
    check("frame_abort", abort_cnt[d] - ab0, abort_exp);
    check("rx_pending", exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn0, ab0;
    for (int i = 0; i < 3; i++) begin
      und_cnt[i] = 0; done_cnt[i] = 0; abort_cnt[i] = 0; txd[i] = '0;
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_miso", {31'd0, miso_a}, 0);
    check("rst_miso_oe", {31'd0, oe_a}, 0);
    check("rst_tx_ready", {31'd0, ifa.tx_ready}, 1);
    check("rst_rx_data", {24'd0, ifa.rx_data}, 0);
    check("rst_word_count", {16'd0, ifa.word_count}, 0);
    check("rst_frame_active", {31'd0, ifa.frame_active}, 0);
    check("rst_tx_ready_c", {31'd0, ifc.tx_ready}, 1);

    // Mode 0: 0x89 out, 0xA5 in; a spare word feeds the final trailing-edge load.
    tx_push(0, 32'h89);
    mw_g[0] = 32'hA5; em_g[0] = 32'h89;
    fork
      run_frame(0, 1, 8, 1'b1, 1, 0, 0);
      tx_push(0, 32'h00);
    join

    // Back-to-back three words, refilled as tx_ready rises.
    tx_push(0, 32'h12);
    mw_g[0] = 32'h01; mw_g[1] = 32'h02; mw_g[2] = 32'h03;
    em_g[0] = 32'h12; em_g[1] = 32'h34; em_g[2] = 32'h56;
    fork
      run_frame(0, 3, 8, 1'b1, 3, 0, 0);
      begin
        tx_push(0, 32'h34);
        tx_push(0, 32'h56);
        tx_push(0, 32'h00);
      end
    join

    // Abort after 5 of 8 bits.
    tx_push(0, 32'h5A);
    mw_g[0] = 32'hFF;
    run_frame(0, 1, 5, 1'b0, 0, 0, 1);

    // CPOL=1 CPHA=1 16-bit LSB-first.
    tx_push(2, 32'hBEEF);
    mw_g[0] = 32'h1234; em_g[0] = 32'hBEEF;
    run_frame(2, 1, 16, 1'b1, 1, 0, 0);

    // Underrun with TX_FILL=1 on a CPHA=1 slave: only the second word's load is empty.
    tx_push(1, 32'h3C);
    mw_g[0] = 32'h11; mw_g[1] = 32'h22;
    em_g[0] = 32'h3C; em_g[1] = 32'hFF;
    run_frame(1, 2, 8, 1'b1, 2, 1, 0);

    // Reset mid-frame with ssel held low.
    tx_push(0, 32'h77);
    ssel_v[0] = 1'b0;
    #(HALF);
    repeat (3) begin
      sck_v[0] = 1'b1; #(HALF);
      sck_v[0] = 1'b0; #(HALF);
    end
    dn0 = done_cnt[0];
    ab0 = abort_cnt[0];
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_miso", {31'd0, miso_a}, 0);
    check("mid_rst_oe", {31'd0, oe_a}, 0);
    check("mid_rst_tx_ready", {31'd0, ifa.tx_ready}, 1);
    check("mid_rst_rx_data", {24'd0, ifa.rx_data}, 0);
    check("mid_rst_word_count", {16'd0, ifa.word_count}, 0);
    mosi = 1'b1;
    repeat (8) begin
      sck_v[0] = 1'b1; #(HALF);
      sck_v[0] = 1'b0; #(HALF);
    end
    check("ignored_active", {31'd0, ifa.frame_active}, 0);
    check("ignored_oe", {31'd0, oe_a}, 0);
    check("ignored_word_count", {16'd0, ifa.word_count}, 0);
    ssel_v[0] = 1'b1;
    #(2 * HALF);
    check("no_strobe_done", done_cnt[0] - dn0, 0);
    check("no_strobe_abort", abort_cnt[0] - ab0, 0);

    tx_push(0, 32'hC3);
    mw_g[0] = 32'h5A; em_g[0] = 32'hC3;
    fork
      run_frame(0, 1, 8, 1'b1, 1, 0, 0);
      tx_push(0, 32'h00);
    join

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
